priority_arbiter: RTL



---
 rtl/priority_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/priority_arbiter.sv
// Eight-way arbiter that grants either by fixed priority or by downward
// round-robin. A grant is held until done, a request drop, disable, or the MAX_HOLD limit.
module priority_arbiter #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       mode,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] gnt,
   output logic [2:0] gnt_id,
   output logic       gnt_valid,
   output logic       timeout
);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      RELEASE
   } state_t;

   localparam logic [7:0] LIMIT = 8'(MAX_HOLD - 1);

   state_t     state_q, state_d;
   logic [7:0] gnt_q, gnt_d;
   logic [2:0] gnt_id_q, gnt_id_d;
   logic       gnt_valid_q, gnt_valid_d;
   logic       timeout_q, timeout_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] last_id_q, last_id_d;

   logic [2:0] fix_id;
   logic [2:0] rr_id;
   logic [2:0] rr_idx;
   logic [2:0] win_id;
   logic       hold_limit;
   logic       req_drop;

   // Later loop iterations overwrite earlier ones, so the last match wins:
   // ascending order favours the highest index, and descending step order
   // favours the position nearest below last_id.
   always_comb begin
      fix_id = 3'd0;
      rr_id  = 3'd0;
      rr_idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (req[i]) fix_id = 3'(i);
      end
      for (int k = 8; k >= 1; k--) begin
         rr_idx = last_id_q - 3'(k);
         if (req[rr_idx]) rr_id = rr_idx;
      end
      win_id = mode ? rr_id : fix_id;
   end

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gnt_id_d    = gnt_id_q;
      gnt_valid_d = gnt_valid_q;
      timeout_d   = 1'b0;
      cnt_d       = cnt_q;
      last_id_d   = last_id_q;
      hold_limit  = (cnt_q == LIMIT);
      req_drop    = !req[gnt_id_q];

      case (state_q)
         IDLE: begin
            gnt_d       = 8'h00;
            gnt_id_d    = 3'd0;
            gnt_valid_d = 1'b0;
            if (en && (req != 8'h00)) begin
               state_d     = GRANT;
               gnt_d       = 8'b1 << win_id;
               gnt_id_d    = win_id;
               gnt_valid_d = 1'b1;
               cnt_d       = 8'd0;
               last_id_d   = win_id;
            end
         end
         GRANT: begin
            if (done || req_drop || hold_limit || !en) begin
               state_d     = RELEASE;
               gnt_d       = 8'h00;
               gnt_id_d    = 3'd0;
               gnt_valid_d = 1'b0;
               cnt_d       = 8'd0;
               // The limit only reports a timeout when nothing else ended the grant.
               timeout_d   = hold_limit && !done && !req_drop && en;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RELEASE: begin
            state_d     = IDLE;
            gnt_d       = 8'h00;
            gnt_id_d    = 3'd0;
            gnt_valid_d = 1'b0;
         end
         default: begin
            state_d     = IDLE;
            gnt_d       = 8'h00;
            gnt_id_d    = 3'd0;
            gnt_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         gnt_q       <= 8'h00;
         gnt_id_q    <= 3'd0;
         gnt_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
         cnt_q       <= 8'd0;
         last_id_q   <= 3'd0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_id_q    <= gnt_id_d;
         gnt_valid_q <= gnt_valid_d;
         timeout_q   <= timeout_d;
         cnt_q       <= cnt_d;
         last_id_q   <= last_id_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_id    = gnt_id_q;
   assign gnt_valid = gnt_valid_q;
   assign timeout   = timeout_q;

endmodule
